// File: rtl/pll_clk_seq_pkg.sv
// Shared state encoding, configuration record and legality rules for the PLL clock sequencer.
package pll_clk_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_REF,
        S_PROGRAM,
        S_WAIT_LOCK,
        S_TO_PLL,
        S_SOFT_RST,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic        usePll;
        logic [5:0]  refDiv;
        logic [11:0] fbDiv;
        logic [2:0]  postDiv1;
        logic [2:0]  postDiv2;
    } cfg_t;

    localparam int MIN_REF_DIV  = 1;
    localparam int MIN_FB_DIV   = 16;
    localparam int MIN_POST_DIV = 1;

    function automatic logic is_legal_cfg(input cfg_t c);
        return (int'(c.refDiv) >= MIN_REF_DIV) && (int'(c.fbDiv) >= MIN_FB_DIV)
            && (int'(c.postDiv1) >= MIN_POST_DIV) && (int'(c.postDiv2) >= MIN_POST_DIV);
    endfunction

endpackage

// File: rtl/pll_clk_seq_sync_2ff.sv
// Two-flop synchronizer with a selectable reset value, used to bring PLL lock into the reference domain.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/pll_clk_seq.sv
// Sequencer that parks the SoC on the reference clock, reprograms the PLL, qualifies lock
// and switches back to the PLL clock with a soft-reset window; also watches for lock loss.
module pll_clk_seq
    import pll_clk_seq_pkg::*;
#(
    parameter int          SWITCH_CYCLES   = 8,
    parameter int          SETTLE_CYCLES   = 32,
    parameter int          LOCK_STABLE     = 16,
    parameter int          LOCK_TIMEOUT    = 4096,
    parameter int          SOFT_RST_CYCLES = 4,
    parameter logic [5:0]  DEF_REF_DIV     = 6'd1,
    parameter logic [11:0] DEF_FB_DIV      = 12'd64,
    parameter logic [2:0]  DEF_POST_DIV1   = 3'd1,
    parameter logic [2:0]  DEF_POST_DIV2   = 3'd1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic        cfg_use_pll_i,
    input  logic [5:0]  cfg_ref_div_i,
    input  logic [11:0] cfg_fb_div_i,
    input  logic [2:0]  cfg_post_div1_i,
    input  logic [2:0]  cfg_post_div2_i,
    input  logic        pll_lock_i,
    output logic [5:0]  pll_ref_div_o,
    output logic [11:0] pll_feedback_div_o,
    output logic [2:0]  pll_post_div1_o,
    output logic [2:0]  pll_post_div2_o,
    output logic        clk_sel_o,
    output logic        soft_reset_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_timeout_o,
    output logic        err_cfg_o,
    output logic        lock_lost_o
);

    localparam int CNT_MAX_A = (SWITCH_CYCLES > SETTLE_CYCLES) ? SWITCH_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX_B = (LOCK_TIMEOUT > SOFT_RST_CYCLES) ? LOCK_TIMEOUT : SOFT_RST_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int STB_W     = $clog2(LOCK_STABLE + 1);

    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SWITCH_LAST   = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SOFT_RST_LAST = CNT_W'(SOFT_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_TARGET    = STB_W'(LOCK_STABLE);

    state_t           r_state;
    state_t           w_nextState;
    cfg_t             r_cfg;
    cfg_t             w_reqCfg;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntInc;
    logic [STB_W-1:0] r_stable;
    logic [STB_W-1:0] w_stableNext;
    logic [5:0]       r_refDiv;
    logic [11:0]      r_fbDiv;
    logic [2:0]       r_postDiv1;
    logic [2:0]       r_postDiv2;
    logic             r_clkSel;
    logic             r_errTimeout;
    logic             r_errCfg;
    logic             r_lockLost;
    logic             w_lockS;
    logic             w_ready;
    logic             w_legal;
    logic             w_accept;
    logic             w_reject;
    logic             w_timeout;
    logic             w_pllDrop;
    logic             w_idleDrop;

    sync_2ff #(.RESET_VAL(1'b0)) u_lockSync (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_d     (pll_lock_i),
        .o_q     (w_lockS)
    );

    assign w_reqCfg = '{usePll: cfg_use_pll_i, refDiv: cfg_ref_div_i, fbDiv: cfg_fb_div_i,
                        postDiv1: cfg_post_div1_i, postDiv2: cfg_post_div2_i};
    assign w_legal    = is_legal_cfg(w_reqCfg);
    assign w_ready    = (r_state == S_IDLE) || (r_state == S_ERROR);
    assign w_accept   = cfg_valid_i && w_ready && w_legal;
    assign w_reject   = cfg_valid_i && w_ready && !w_legal;
    assign w_cntInc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
    // A legal request in the same cycle takes precedence; it moves us off the PLL anyway.
    assign w_idleDrop = (r_state == S_IDLE) && r_clkSel && !w_lockS && !w_accept;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_stableNext = '0;
        w_timeout    = 1'b0;
        w_pllDrop    = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (w_accept) w_nextState = S_TO_REF;
            end
            S_TO_REF: begin
                if (r_cnt == SWITCH_LAST) w_nextState = S_PROGRAM;
            end
            S_PROGRAM: begin
                if (r_cnt == SETTLE_LAST) w_nextState = r_cfg.usePll ? S_WAIT_LOCK : S_DONE;
            end
            S_WAIT_LOCK: begin
                if (w_lockS) begin
                    w_stableNext = (r_stable == STB_TARGET) ? r_stable : r_stable + STB_W'(1);
                end
                // Lock is checked first so it wins a tie with the timeout.
                if (w_stableNext == STB_TARGET) begin
                    w_nextState = S_TO_PLL;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_nextState = S_ERROR;
                    w_timeout   = 1'b1;
                end
            end
            S_TO_PLL: begin
                if (!w_lockS) begin
                    w_nextState = S_ERROR;
                    w_pllDrop   = 1'b1;
                end else if (r_cnt == SWITCH_LAST) begin
                    w_nextState = S_SOFT_RST;
                end
            end
            S_SOFT_RST: begin
                if (r_cnt == SOFT_RST_LAST) w_nextState = S_DONE;
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt        <= '0;
            r_stable     <= '0;
            r_cfg        <= '{usePll: 1'b0, refDiv: DEF_REF_DIV, fbDiv: DEF_FB_DIV,
                              postDiv1: DEF_POST_DIV1, postDiv2: DEF_POST_DIV2};
            r_refDiv     <= DEF_REF_DIV;
            r_fbDiv      <= DEF_FB_DIV;
            r_postDiv1   <= DEF_POST_DIV1;
            r_postDiv2   <= DEF_POST_DIV2;
            r_clkSel     <= 1'b0;
            r_errTimeout <= 1'b0;
            r_errCfg     <= 1'b0;
            r_lockLost   <= 1'b0;
        end else begin
            if (w_nextState != r_state) begin
                r_cnt    <= '0;
                r_stable <= '0;
            end else begin
                r_cnt    <= w_cntInc;
                r_stable <= w_stableNext;
            end
            if (w_accept) begin
                r_cfg        <= w_reqCfg;
                r_clkSel     <= 1'b0;
                r_errTimeout <= 1'b0;
                r_errCfg     <= 1'b0;
                r_lockLost   <= 1'b0;
            end
            if (w_reject) begin
                r_errCfg <= 1'b1;
            end
            if ((r_state == S_TO_REF) && (w_nextState == S_PROGRAM)) begin
                r_refDiv   <= r_cfg.refDiv;
                r_fbDiv    <= r_cfg.fbDiv;
                r_postDiv1 <= r_cfg.postDiv1;
                r_postDiv2 <= r_cfg.postDiv2;
            end
            if ((r_state == S_WAIT_LOCK) && (w_nextState == S_TO_PLL)) begin
                r_clkSel <= 1'b1;
            end
            if (w_timeout) begin
                r_errTimeout <= 1'b1;
            end
            if (w_pllDrop || w_idleDrop) begin
                r_clkSel   <= 1'b0;
                r_lockLost <= 1'b1;
            end
        end
    end

    assign cfg_ready_o        = w_ready;
    assign busy_o             = !w_ready;
    assign soft_reset_en_o    = (r_state == S_SOFT_RST);
    assign done_o             = (r_state == S_DONE);
    assign clk_sel_o          = r_clkSel;
    assign pll_ref_div_o      = r_refDiv;
    assign pll_feedback_div_o = r_fbDiv;
    assign pll_post_div1_o    = r_postDiv1;
    assign pll_post_div2_o    = r_postDiv2;
    assign err_timeout_o      = r_errTimeout;
    assign err_cfg_o          = r_errCfg;
    assign lock_lost_o        = r_lockLost;

endmodule

// File: tb/tb_pll_clk_seq.sv
// Directed plus randomized bench for pll_clk_seq; expected timelines come from an arithmetic
// model of the sequence (phase lengths and a consecutive-lock-window rule).
module tb_pll_clk_seq;

    localparam int SWITCH_CYCLES   = 8;
    localparam int SETTLE_CYCLES   = 32;
    localparam int LOCK_STABLE     = 16;
    localparam int LOCK_TIMEOUT    = 4096;
    localparam int SOFT_RST_CYCLES = 4;
    localparam int NEVER           = 1000000;
    localparam logic [23:0] DEF_DIVS = {6'd1, 12'd64, 3'd1, 3'd1};

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        cfg_use_pll_i = 1'b0;
    logic [5:0]  cfg_ref_div_i = '0;
    logic [11:0] cfg_fb_div_i = '0;
    logic [2:0]  cfg_post_div1_i = '0;
    logic [2:0]  cfg_post_div2_i = '0;
    logic        pll_lock_i = 1'b0;
    logic [5:0]  pll_ref_div_o;
    logic [11:0] pll_feedback_div_o;
    logic [2:0]  pll_post_div1_o;
    logic [2:0]  pll_post_div2_o;
    logic        clk_sel_o;
    logic        soft_reset_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_timeout_o;
    logic        err_cfg_o;
    logic        lock_lost_o;

    int          checkCount = 0;
    int          passCount = 0;
    int          failCount = 0;
    logic [23:0] modelDiv = DEF_DIVS;

    pll_clk_seq #(
        .SWITCH_CYCLES   (SWITCH_CYCLES),
        .SETTLE_CYCLES   (SETTLE_CYCLES),
        .LOCK_STABLE     (LOCK_STABLE),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .SOFT_RST_CYCLES (SOFT_RST_CYCLES)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cfg_valid_i        (cfg_valid_i),
        .cfg_ready_o        (cfg_ready_o),
        .cfg_use_pll_i      (cfg_use_pll_i),
        .cfg_ref_div_i      (cfg_ref_div_i),
        .cfg_fb_div_i       (cfg_fb_div_i),
        .cfg_post_div1_i    (cfg_post_div1_i),
        .cfg_post_div2_i    (cfg_post_div2_i),
        .pll_lock_i         (pll_lock_i),
        .pll_ref_div_o      (pll_ref_div_o),
        .pll_feedback_div_o (pll_feedback_div_o),
        .pll_post_div1_o    (pll_post_div1_o),
        .pll_post_div2_o    (pll_post_div2_o),
        .clk_sel_o          (clk_sel_o),
        .soft_reset_en_o    (soft_reset_en_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_timeout_o      (err_timeout_o),
        .err_cfg_o          (err_cfg_o),
        .lock_lost_o        (lock_lost_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #(800_000);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    function automatic logic [23:0] divsNow();
        return {pll_ref_div_o, pll_feedback_div_o, pll_post_div1_o, pll_post_div2_o};
    endfunction

    function automatic logic lockRaw(input int k, input int riseAt, input int glitchAt);
        return (k >= riseAt) && (k != glitchAt);
    endfunction

    task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkIdleFlags(input string tag, input logic expClkSel, input logic expErrCfg,
                                  input logic expLockLost);
        checkOutput({tag, "_busy"}, -1, 32'(busy_o), 32'(1'b0));
        checkOutput({tag, "_ready"}, -1, 32'(cfg_ready_o), 32'(1'b1));
        checkOutput({tag, "_clksel"}, -1, 32'(clk_sel_o), 32'(expClkSel));
        checkOutput({tag, "_errcfg"}, -1, 32'(err_cfg_o), 32'(expErrCfg));
        checkOutput({tag, "_locklost"}, -1, 32'(lock_lost_o), 32'(expLockLost));
        checkOutput({tag, "_divs"}, -1, 32'(divsNow()), 32'(modelDiv));
    endtask

    // Entered and left at a falling edge; k counts rising edges after the accepting edge.
    task automatic applyStimulus(input logic usePll, input logic [5:0] refDiv,
                                 input logic [11:0] fbDiv, input logic [2:0] pd1,
                                 input logic [2:0] pd2, input int riseAt, input int glitchAt);
        int          wEntry;
        int          runStart;
        int          pEntry;
        int          doneK;
        int          errK;
        int          endK;
        logic        timedOut;
        logic        expBusy;
        logic [23:0] newDiv;
        wEntry   = SWITCH_CYCLES + SETTLE_CYCLES;
        runStart = (riseAt + 2 > wEntry) ? riseAt + 2 : wEntry;
        if (glitchAt >= 0 && glitchAt + 2 >= runStart && glitchAt + 2 < runStart + LOCK_STABLE)
            runStart = glitchAt + 3;
        pEntry   = runStart + LOCK_STABLE;
        errK     = wEntry + LOCK_TIMEOUT;
        timedOut = usePll && (pEntry > errK);
        doneK    = usePll ? pEntry + SWITCH_CYCLES + SOFT_RST_CYCLES : wEntry;
        endK     = timedOut ? errK : doneK + 1;
        newDiv   = {refDiv, fbDiv, pd1, pd2};

        checkOutput("ready_before_req", -1, 32'(cfg_ready_o), 32'(1'b1));
        cfg_use_pll_i   = usePll;
        cfg_ref_div_i   = refDiv;
        cfg_fb_div_i    = fbDiv;
        cfg_post_div1_i = pd1;
        cfg_post_div2_i = pd2;
        cfg_valid_i     = 1'b1;
        @(posedge clk_i);
        #1 cfg_valid_i = 1'b0;

        for (int k = 0; k <= endK; k++) begin
            @(negedge clk_i);
            pll_lock_i = lockRaw(k, riseAt, glitchAt);
            expBusy = timedOut ? (k < errK) : (k <= doneK);
            checkOutput("busy", k, 32'(busy_o), 32'(expBusy));
            checkOutput("ready", k, 32'(cfg_ready_o), 32'(!expBusy));
            checkOutput("clk_sel", k, 32'(clk_sel_o), 32'(usePll && !timedOut && k >= pEntry));
            checkOutput("soft_rst", k, 32'(soft_reset_en_o),
                        32'(usePll && !timedOut && k >= pEntry + SWITCH_CYCLES && k < doneK));
            checkOutput("done", k, 32'(done_o), 32'(!timedOut && k == doneK));
            checkOutput("err_timeout", k, 32'(err_timeout_o), 32'(timedOut && k >= errK));
            checkOutput("err_cfg", k, 32'(err_cfg_o), 32'(1'b0));
            checkOutput("lock_lost", k, 32'(lock_lost_o), 32'(1'b0));
            checkOutput("divs", k, 32'(divsNow()), 32'((k >= SWITCH_CYCLES) ? newDiv : modelDiv));
        end
        modelDiv = newDiv;
    endtask

    initial begin
        logic        rUse;
        logic [5:0]  rRef;
        logic [11:0] rFb;
        logic [2:0]  rPd1;
        logic [2:0]  rPd2;
        int          rRise;
        int          rGlitch;

        $display("[TB] reset check");
        #12;
        checkOutput("rst_clksel", -1, 32'(clk_sel_o), 32'(1'b0));
        checkOutput("rst_divs", -1, 32'(divsNow()), 32'(DEF_DIVS));
        checkOutput("rst_busy", -1, 32'(busy_o), 32'(1'b0));
        checkOutput("rst_ready", -1, 32'(cfg_ready_o), 32'(1'b1));
        checkOutput("rst_done", -1, 32'(done_o), 32'(1'b0));
        checkOutput("rst_soft", -1, 32'(soft_reset_en_o), 32'(1'b0));
        checkOutput("rst_errs", -1, 32'({err_timeout_o, err_cfg_o, lock_lost_o}), 32'(3'b000));
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] nominal PLL sequence, lock 10 cycles after settle");
        applyStimulus(1'b1, 6'd2, 12'd100, 3'd2, 3'd1, 50, -1);

        $display("[TB] lock drop while idle on PLL");
        pll_lock_i = 1'b0;
        @(negedge clk_i);
        checkOutput("drop_c1_clksel", 1, 32'(clk_sel_o), 32'(1'b1));
        @(negedge clk_i);
        checkOutput("drop_c2_clksel", 2, 32'(clk_sel_o), 32'(1'b1));
        @(negedge clk_i);
        checkOutput("drop_c3_clksel", 3, 32'(clk_sel_o), 32'(1'b0));
        checkOutput("drop_c3_locklost", 3, 32'(lock_lost_o), 32'(1'b1));
        checkOutput("drop_c3_busy", 3, 32'(busy_o), 32'(1'b0));

        $display("[TB] lock glitch restarts the stability window");
        applyStimulus(1'b1, 6'd3, 12'd200, 3'd1, 3'd1, 40, 50);

        $display("[TB] illegal feedback divider rejected");
        cfg_use_pll_i   = 1'b1;
        cfg_ref_div_i   = 6'd4;
        cfg_fb_div_i    = 12'd8;
        cfg_post_div1_i = 3'd2;
        cfg_post_div2_i = 3'd2;
        cfg_valid_i     = 1'b1;
        repeat (3) @(negedge clk_i);
        checkIdleFlags("reject", 1'b1, 1'b1, 1'b0);
        cfg_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkIdleFlags("reject_after", 1'b1, 1'b1, 1'b0);

        $display("[TB] lock never arrives");
        applyStimulus(1'b1, 6'd1, 12'd16, 3'd1, 3'd1, NEVER, -1);

        $display("[TB] retry from error onto reference clock");
        applyStimulus(1'b0, 6'd4, 12'd50, 3'd3, 3'd3, NEVER, -1);

        $display("[TB] randomized sequences");
        for (int i = 0; i < 4; i++) begin
            rUse    = 1'($urandom_range(0, 1));
            rRef    = 6'($urandom_range(1, 63));
            rFb     = 12'($urandom_range(16, 4095));
            rPd1    = 3'($urandom_range(1, 7));
            rPd2    = 3'($urandom_range(1, 7));
            rRise   = int'($urandom_range(20, 80));
            rGlitch = ($urandom_range(0, 1) == 1) ? rRise + int'($urandom_range(0, 14)) : -1;
            applyStimulus(rUse, rRef, rFb, rPd1, rPd2, rRise, rGlitch);
        end

        $display("[TB] reset asserted during lock wait");
        pll_lock_i      = 1'b0;
        cfg_use_pll_i   = 1'b1;
        cfg_ref_div_i   = 6'd5;
        cfg_fb_div_i    = 12'd300;
        cfg_post_div1_i = 3'd3;
        cfg_post_div2_i = 3'd2;
        cfg_valid_i     = 1'b1;
        @(posedge clk_i);
        #1 cfg_valid_i = 1'b0;
        repeat (45) @(posedge clk_i);
        #2;
        checkOutput("prerst_busy", 45, 32'(busy_o), 32'(1'b1));
        checkOutput("prerst_divs", 45, 32'(divsNow()), 32'({6'd5, 12'd300, 3'd3, 3'd2}));
        rstn_i = 1'b0;
        #1;
        checkOutput("midrst_clksel", -1, 32'(clk_sel_o), 32'(1'b0));
        checkOutput("midrst_divs", -1, 32'(divsNow()), 32'(DEF_DIVS));
        checkOutput("midrst_busy", -1, 32'(busy_o), 32'(1'b0));
        checkOutput("midrst_ready", -1, 32'(cfg_ready_o), 32'(1'b1));
        checkOutput("midrst_soft_done", -1, 32'({soft_reset_en_o, done_o}), 32'(2'b00));
        @(negedge clk_i);
        rstn_i   = 1'b1;
        modelDiv = DEF_DIVS;
        repeat (2) @(negedge clk_i);
        checkIdleFlags("postrst", 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
